video_timing: RTL and testbench



---
 rtl/video_timing.sv | 119 +++++++++++
 tb/tb_video_timing.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// video_timing
// ------------
// Raster timing and video-RAM address generator feeding the pixel serialiser.
// Three cascaded counters walk the raster: px (pixel within an 8-pixel
// character), hc (character within a line) and vc (line within a frame).
// Each counter advances only on a clock edge where ce is high.
// Every output except irq is a pure decode of the current counter values.
//
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous, active-low reset
//   ce      in   pixel clock-enable
//   phase   out  pixel index within the current character (0..7)
//   de      out  display enable (active area)
//   addr    out  VRAM byte address {line[7:0], char[4:0]}, held for a character
//   hsync   out  horizontal sync, active high
//   vsync   out  vertical sync, active high
//   hblank  out  horizontal blank
//   vblank  out  vertical blank
//   irq     out  one-clock frame interrupt at the start of vertical blank
module video_timing #(
    parameter int H_ACTIVE     = 32,
    parameter int H_SYNC_START = 40,
    parameter int H_SYNC_WIDTH = 4,
    parameter int H_TOTAL      = 48,
    parameter int V_ACTIVE     = 248,
    parameter int V_SYNC_START = 270,
    parameter int V_SYNC_WIDTH = 3,
    parameter int V_TOTAL      = 312
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    output logic [2:0]  phase,
    output logic        de,
    output logic [12:0] addr,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic        irq
);

    // The horizontal and vertical compare values are one bit wider than their
    // counters. A sync window can end exactly at the total (64 or 512), and
    // that end value would not fit in the counter width.
    localparam logic [6:0] H_ACT_W   = 7'(H_ACTIVE);
    localparam logic [6:0] H_SS_W    = 7'(H_SYNC_START);
    localparam logic [6:0] H_SE_W    = 7'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [5:0] H_LAST    = 6'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_W   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS_W    = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE_W    = 10'(V_SYNC_START + V_SYNC_WIDTH);
    localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_PRE_IRQ = 9'(V_ACTIVE - 1);

    logic [2:0] px_q, px_d;
    logic [5:0] hc_q, hc_d;
    logic [8:0] vc_q, vc_d;
    logic       irq_q, irq_d;
    logic       lastPx, lastHc, lastVc;

    assign lastPx = (px_q == 3'd7);
    assign lastHc = (hc_q == H_LAST);
    assign lastVc = (vc_q == V_LAST);

    // Next-state logic for the counter cascade.
    // px wraps naturally at 7. hc advances on each px wrap, and vc advances
    // when both px and hc wrap on the same edge. irq_d is recomputed on every
    // clock, so the pulse drops on the next edge even if ce is low.
    always_comb begin
        px_d  = px_q;
        hc_d  = hc_q;
        vc_d  = vc_q;
        irq_d = 1'b0;
        if (ce) begin
            px_d = px_q + 3'd1;
            if (lastPx) begin
                if (lastHc) begin
                    hc_d = '0;
                    vc_d = lastVc ? '0 : vc_q + 9'd1;
                end else begin
                    hc_d = hc_q + 6'd1;
                end
            end
            // The edge that moves the counters onto (V_ACTIVE, 0, 0) raises irq.
            irq_d = lastPx && lastHc && (vc_q == V_PRE_IRQ);
        end
    end

    // State register. The asynchronous reset returns the raster to the top-left pixel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            px_q  <= '0;
            hc_q  <= '0;
            vc_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            px_q  <= px_d;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            irq_q <= irq_d;
        end
    end

    // Output decodes. addr is built only from hc and vc, so it stays constant
    // for all eight phases of a character.
    always_comb begin
        phase  = px_q;
        hblank = ({1'b0, hc_q} >= H_ACT_W);
        vblank = ({1'b0, vc_q} >= V_ACT_W);
        de     = !hblank && !vblank;
        hsync  = ({1'b0, hc_q} >= H_SS_W) && ({1'b0, hc_q} < H_SE_W);
        vsync  = ({1'b0, vc_q} >= V_SS_W) && ({1'b0, vc_q} < V_SE_W);
        addr   = {vc_q[7:0], hc_q[4:0]};
        irq    = irq_q;
    end

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing
// Self-checking bench for video_timing. Two instances share one stimulus
// stream. One instance uses the default raster. The other uses a small raster,
// so that whole frames (vblank, vsync, irq and the frame wrap) fit in a short run.
// The expected outputs of both come from a reference model. The model derives
// the counters with plain division of the number of ce edges seen since reset.
module tb_video_timing;

    logic        clock;
    logic        reset;
    logic        ce;

    logic [2:0]  phaseD, phaseS;
    logic        deD, deS, hsD, hsS, vsD, vsS, hbD, hbS, vbD, vbS, irqD, irqS;
    logic [12:0] addrD, addrS;
    logic [21:0] obsD, obsS, expD, expS;

    int          nCe;
    bit          lastCe;
    int          cmpCount;
    int          errCount;

    video_timing uDefault (
        .clock (clock), .reset (reset), .ce (ce),
        .phase (phaseD), .de (deD), .addr (addrD),
        .hsync (hsD), .vsync (vsD), .hblank (hbD), .vblank (vbD), .irq (irqD)
    );

    video_timing #(
        .H_ACTIVE (8),  .H_SYNC_START (9),  .H_SYNC_WIDTH (2), .H_TOTAL (12),
        .V_ACTIVE (12), .V_SYNC_START (14), .V_SYNC_WIDTH (3), .V_TOTAL (20)
    ) uSmall (
        .clock (clock), .reset (reset), .ce (ce),
        .phase (phaseS), .de (deS), .addr (addrS),
        .hsync (hsS), .vsync (vsS), .hblank (hbS), .vblank (vbS), .irq (irqS)
    );

    assign obsD = {phaseD, deD, addrD, hsD, vsD, hbD, vbD, irqD};
    assign obsS = {phaseS, deS, addrS, hsS, vsS, hbS, vbS, irqS};

    // 100 MHz-style free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model. It takes the number of ce edges since reset and a flag
    // for whether the latest edge carried ce, and returns the expected output
    // vector. Rasters are treated as plain arithmetic positions in a frame.
    function automatic logic [21:0] model(input int n, input bit ceEdge,
                                          input int ha, input int hss, input int hsw, input int ht,
                                          input int va, input int vss, input int vsw, input int vt);
        int          frame, m, px, hc, vc;
        logic        hb, vb, hs, vs, dv, iq;
        logic [12:0] ad;
        frame = 8 * ht * vt;
        m     = n % frame;
        px    = m % 8;
        hc    = (m / 8) % ht;
        vc    = m / (8 * ht);
        hb    = (hc >= ha);
        vb    = (vc >= va);
        dv    = !hb && !vb;
        hs    = (hc >= hss) && (hc < hss + hsw);
        vs    = (vc >= vss) && (vc < vss + vsw);
        ad    = 13'((vc % 256) * 32 + (hc % 32));
        iq    = ceEdge && (m == 8 * ht * va);
        return {3'(px), dv, ad, hs, vs, hb, vb, iq};
    endfunction

    // Predict both instances from the current model state
    task automatic predict();
        expD = model(nCe, lastCe, 32, 40, 4, 48, 248, 270, 3, 312);
        expS = model(nCe, lastCe, 8, 9, 2, 12, 12, 14, 3, 20);
    endtask

    // One clock with the given ce. The model counts only while out of reset.
    // Outputs are sampled 1 ns after the edge.
    task automatic applyStimulus(input logic c);
        ce = c;
        @(posedge clock);
        if (reset) begin
            if (c) nCe++;
            lastCe = c;
        end
        #1;
    endtask

    // Reset held low: everything must sit at the top-left reset values
    task automatic test_reset();
        reset  = 1'b0;
        ce     = 1'b1;
        nCe    = 0;
        lastCe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'(i % 2));
            cmpCount++;
            if (obsD !== {3'd0, 1'b1, 13'd0, 5'b00000}) begin
                errCount++;
                $display("[TB] FAIL reset_default got=%h exp=%h", obsD, {3'd0, 1'b1, 13'd0, 5'b00000});
            end
            cmpCount++;
            if (obsS !== {3'd0, 1'b1, 13'd0, 5'b00000}) begin
                errCount++;
                $display("[TB] FAIL reset_small got=%h exp=%h", obsS, {3'd0, 1'b1, 13'd0, 5'b00000});
            end
        end
        #2 reset = 1'b1;
    endtask

    // First line and a bit of the second with ce high every clock
    task automatic test_first_line();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b1);
            predict();
            cmpCount++;
            if (obsD !== expD) begin
                errCount++;
                $display("[TB] FAIL first_line_default n=%0d got=%h exp=%h", nCe, obsD, expD);
            end
            cmpCount++;
            if (obsS !== expS) begin
                errCount++;
                $display("[TB] FAIL first_line_small n=%0d got=%h exp=%h", nCe, obsS, expS);
            end
        end
    endtask

    // ce one clock in three: outputs must hold across the gaps
    task automatic test_ce_gaps();
        for (int i = 0; i < 3 * 400; i++) begin
            applyStimulus(1'(i % 3 == 0));
            predict();
            cmpCount++;
            if (obsD !== expD) begin
                errCount++;
                $display("[TB] FAIL ce_gap_default n=%0d got=%h exp=%h", nCe, obsD, expD);
            end
            cmpCount++;
            if (obsS !== expS) begin
                errCount++;
                $display("[TB] FAIL ce_gap_small n=%0d got=%h exp=%h", nCe, obsS, expS);
            end
        end
    endtask

    // Randomised ce density over several small frames
    task automatic test_random_ce();
        for (int i = 0; i < 6000; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0));
            predict();
            cmpCount++;
            if (obsD !== expD) begin
                errCount++;
                $display("[TB] FAIL random_default n=%0d got=%h exp=%h", nCe, obsD, expD);
            end
            cmpCount++;
            if (obsS !== expS) begin
                errCount++;
                $display("[TB] FAIL random_small n=%0d got=%h exp=%h", nCe, obsS, expS);
            end
        end
    endtask

    // Continuous ce over more than two small frames. The bench also measures
    // the irq spacing directly: pulses must be one clock wide and exactly one
    // frame of ce apart.
    task automatic test_frame_irq();
        int irqAt[$];
        for (int i = 0; i < 2 * 1920 + 200; i++) begin
            applyStimulus(1'b1);
            predict();
            if (irqS === 1'b1) irqAt.push_back(nCe);
            cmpCount++;
            if (obsS !== expS) begin
                errCount++;
                $display("[TB] FAIL frame_small n=%0d got=%h exp=%h", nCe, obsS, expS);
            end
            cmpCount++;
            if (obsD !== expD) begin
                errCount++;
                $display("[TB] FAIL frame_default n=%0d got=%h exp=%h", nCe, obsD, expD);
            end
        end
        cmpCount++;
        if (irqAt.size() < 2) begin
            errCount++;
            $display("[TB] FAIL irq_count got=%0d exp>=2", irqAt.size());
        end else begin
            for (int k = 1; k < irqAt.size(); k++) begin
                cmpCount++;
                if (irqAt[k] - irqAt[k-1] != 1920) begin
                    errCount++;
                    $display("[TB] FAIL irq_spacing got=%0d exp=1920", irqAt[k] - irqAt[k-1]);
                end
            end
        end
    endtask

    // Reach (vc=100, hc=20, px=5) on the default raster, then pull reset low
    // between edges. The outputs must return to the reset values with no clock
    // edge, and counting must restart cleanly after release.
    task automatic test_async_reset();
        reset  = 1'b0;
        nCe    = 0;
        lastCe = 1'b0;
        #2 reset = 1'b1;
        for (int i = 0; i < 100 * 384 + 20 * 8 + 5; i++) begin
            applyStimulus(1'b1);
            if (i % 64 == 0) begin
                predict();
                cmpCount++;
                if (obsD !== expD) begin
                    errCount++;
                    $display("[TB] FAIL long_run_default n=%0d got=%h exp=%h", nCe, obsD, expD);
                end
            end
        end
        cmpCount++;
        if ({phaseD, addrD} !== {3'd5, 8'd100, 5'd20}) begin
            errCount++;
            $display("[TB] FAIL pre_reset_position got=%h exp=%h", {phaseD, addrD}, {3'd5, 8'd100, 5'd20});
        end
        #2 reset = 1'b0;
        nCe    = 0;
        lastCe = 1'b0;
        #1;
        cmpCount++;
        if (obsD !== {3'd0, 1'b1, 13'd0, 5'b00000}) begin
            errCount++;
            $display("[TB] FAIL async_reset_default got=%h exp=%h", obsD, {3'd0, 1'b1, 13'd0, 5'b00000});
        end
        cmpCount++;
        if (obsS !== {3'd0, 1'b1, 13'd0, 5'b00000}) begin
            errCount++;
            $display("[TB] FAIL async_reset_small got=%h exp=%h", obsS, {3'd0, 1'b1, 13'd0, 5'b00000});
        end
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        #2 reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1);
            predict();
            cmpCount++;
            if (obsD !== expD) begin
                errCount++;
                $display("[TB] FAIL restart_default n=%0d got=%h exp=%h", nCe, obsD, expD);
            end
            cmpCount++;
            if (obsS !== expS) begin
                errCount++;
                $display("[TB] FAIL restart_small n=%0d got=%h exp=%h", nCe, obsS, expS);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        cmpCount = 0;
        errCount = 0;
        reset    = 1'b0;
        ce       = 1'b0;
        nCe      = 0;
        lastCe   = 1'b0;
        test_reset();
        test_first_line();
        test_ce_gaps();
        test_random_ce();
        test_frame_irq();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
